alu_issue_ctrl: RTL and testbench

Multi-cycle issue controller that drives the combinational ALU from the opposite side of its Src_1/Src_2/Funct → Result/Carry interface. It accepts R-type instructions over a valid/ready handshake and reads operands from an internal 32×32 register file. It presents the operands and Funct to the ALU, captures Result and Carry, and writes the result back to rd. It sits between the instruction source of the PA1 datapath and the ALU.

---
 rtl/alu_issue_ctrl_if.sv | 19 +
 rtl/alu_issue_ctrl.sv | 150 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake between the instruction source and alu_issue_ctrl.
// master: drives instr_valid/instr; slave: drives instr_ready.
interface alu_issue_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Four-state issue controller: accept R-type, read regfile, drive ALU,
// write back. Ports: clk, rst, ib (instr handshake, slave), Src_1/Src_2/
// Funct/Result/Carry (ALU side), done/err/wb_data (retire status),
// carry_flag/carry_clr, dbg_addr/dbg_data (debug read).
// Option: ALU_ISSUE_STICKY_CARRY_EN makes carry_flag sticky until carry_clr.
module alu_issue_ctrl (
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.slave  ib,
  output logic [31:0]      Src_1,
  output logic [31:0]      Src_2,
  output logic [5:0]       Funct,
  input  logic [31:0]      Result,
  input  logic             Carry,
  output logic             done,
  output logic             err,
  output logic [31:0]      wb_data,
  output logic             carry_flag,
  input  logic             carry_clr,
  input  logic [4:0]       dbg_addr,
  output logic [31:0]      dbg_data
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WB
  } state_t;

  state_t      state;
  state_t      nxt;

  logic [5:0]  op_q;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic [4:0]  rd_q;
  logic [5:0]  fn_q;
  logic        carry_q;
  logic [31:0] rf [32];

  logic        legal;
  logic        is_add;
  logic        wr_en;

  // shamt is ignored; carry_clr only matters in the sticky build
  logic        unused_in;
`ifdef ALU_ISSUE_STICKY_CARRY_EN
  assign unused_in = ^ib.instr[10:6];
`else
  assign unused_in = ^{ib.instr[10:6], carry_clr};
`endif

  assign is_add = (fn_q == 6'b000001);
  assign legal  = (op_q == 6'd0) &&
                  (is_add || fn_q == 6'b000000);
  assign wr_en  = (state == WB) && legal &&
                  (rd_q != 5'd0);

  assign ib.instr_ready = (state == IDLE) && !rst;
  assign dbg_data       = rf[dbg_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (ib.instr_valid) nxt = READ;
      READ: nxt = EXEC;
      EXEC: nxt = WB;
      WB:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      fn_q    <= '0;
      Src_1   <= '0;
      Src_2   <= '0;
      Funct   <= '0;
      carry_q <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      wb_data <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ib.instr_valid) begin
            op_q <= ib.instr[31:26];
            rs_q <= ib.instr[25:21];
            rt_q <= ib.instr[20:16];
            rd_q <= ib.instr[15:11];
            fn_q <= ib.instr[5:0];
          end
        end
        READ: begin
          Src_1 <= rf[rs_q];
          Src_2 <= rf[rt_q];
          Funct <= fn_q;
        end
        EXEC: begin
          // ALU has had a full cycle to settle on Src_1/Src_2/Funct
          carry_q <= Carry;
          done    <= 1'b1;
          err     <= !legal;
          wb_data <= legal ? Result : 32'd0;
        end
        WB: ;
        default: ;
      endcase
    end
  end

  // rf[0] is never written, so it always reads zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[rd_q] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_flag <= 1'b0;
    end else begin
`ifdef ALU_ISSUE_STICKY_CARRY_EN
      // a carry-setting retire beats a simultaneous clear
      if ((state == WB) && legal && is_add && carry_q)
        carry_flag <= 1'b1;
      else if (carry_clr)
        carry_flag <= 1'b0;
`else
      if ((state == WB) && legal)
        carry_flag <= is_add && carry_q;
`endif
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU
// and a register-file reference model.
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Src_1, Src_2, Result, wb_data, dbg_data;
  logic [5:0]  Funct;
  logic        Carry, done, err, carry_flag, carry_clr;
  logic [4:0]  dbg_addr;
  logic        ovr_en;
  logic [31:0] ovr_val;

  logic [31:0] m [32];
  logic        mflag;
  int          nchk = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl_if ib ();

  alu_issue_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .ib         (ib),
    .Src_1      (Src_1),
    .Src_2      (Src_2),
    .Funct      (Funct),
    .Result     (Result),
    .Carry      (Carry),
    .done       (done),
    .err        (err),
    .wb_data    (wb_data),
    .carry_flag (carry_flag),
    .carry_clr  (carry_clr),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // ALU model; ovr_en lets the bench inject an arbitrary result
  always_comb begin
    if (ovr_en) {Carry, Result} = {1'b0, ovr_val};
    else begin
      case (Funct)
        6'h01:   {Carry, Result} = {1'b0, Src_1} + {1'b0, Src_2};
        6'h22:   {Carry, Result} = {1'b0, Src_1 - Src_2};
        default: {Carry, Result} = {1'b0, Src_1};
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [5:0] fn);
    logic [4:0] sh;
    sh = 5'($urandom_range(0, 31));
    return {op, rs, rt, rd, sh, fn};
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (ib.instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(ib.instr_ready), 32'd1);
  endtask

  task automatic issue(input logic [31:0] w, input bit hold,
    input logic [31:0] nxt, input bit ov, input logic [31:0] ovv,
    input bit clr);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    bit          lg, isadd;
    logic [32:0] s;
    logic [31:0] res;
    logic        c;
    op = w[31:26]; rs = w[25:21]; rt = w[20:16];
    rd = w[15:11]; fn = w[5:0];
    lg = (op == 6'd0) && (fn == 6'd0 || fn == 6'd1);
    isadd = (fn == 6'd1);
    s = {1'b0, m[rs]} + {1'b0, m[rt]};
    if (isadd) begin res = s[31:0]; c = s[32]; end
    else begin res = ov ? ovv : m[rs]; c = 1'b0; end
    wait_ready();
    ovr_en = ov; ovr_val = ovv; carry_clr = clr;
    ib.instr_valid = 1'b1; ib.instr = w;
    @(posedge clk); #1;
    if (hold) ib.instr = nxt;
    else      ib.instr_valid = 1'b0;
    @(negedge clk);
    chk("read_ready", 32'(ib.instr_ready), 32'd0);
    chk("read_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("exec_done", 32'(done), 32'd0);
    chk("exec_src1", Src_1, m[rs]);
    chk("exec_src2", Src_2, m[rt]);
    chk("exec_funct", 32'(Funct), 32'(fn));
    @(negedge clk);
    chk("wb_done", 32'(done), 32'd1);
    chk("wb_err", 32'(err), 32'(!lg));
    chk("wb_data", wb_data, lg ? res : 32'd0);
    dbg_addr = rd;
    if (lg && rd != 5'd0) m[rd] = res;
`ifdef ALU_ISSUE_STICKY_CARRY_EN
    if (lg && isadd && c) mflag = 1'b1;
    else if (clr)         mflag = 1'b0;
`else
    if (lg) mflag = isadd & c;
`endif
    @(negedge clk);
    carry_clr = 1'b0; ovr_en = 1'b0;
    chk("post_done", 32'(done), 32'd0);
    chk("post_err", 32'(err), 32'd0);
    chk("post_dbg", dbg_data, m[rd]);
    chk("post_flag", 32'(carry_flag), 32'(mflag));
    chk("post_ready", 32'(ib.instr_ready), 32'd1);
  endtask

  initial begin
    logic [5:0] fn, op;
    int r;
    bit ov;
    rst = 1'b1;
    ib.instr_valid = 1'b0; ib.instr = '0;
    carry_clr = 1'b0; dbg_addr = '0;
    ovr_en = 1'b0; ovr_val = '0;
    for (int i = 0; i < 32; i++) m[i] = '0;
    mflag = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ib.instr_ready), 32'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); #1;
      chk("rst_dbg", dbg_data, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0; #1;
    chk("rel_ready", 32'(ib.instr_ready), 32'd1);
    chk("rel_done", 32'(done), 32'd0);
    chk("rel_wb", wb_data, 32'd0);
    chk("rel_flag", 32'(carry_flag), 32'd0);

    issue(enc(0, 0, 0, 1, 0), 0, 0, 1, 32'hFFFF_FFFF, 0);
    issue(enc(0, 0, 0, 2, 0), 0, 0, 1, 32'd1, 0);
    issue(enc(0, 1, 2, 3, 1), 0, 0, 0, 0, 0);
    issue(enc(0, 1, 1, 0, 1), 0, 0, 0, 0, 0);
    issue(enc(0, 0, 0, 7, 0), 0, 0, 1, 32'h1234_5678, 0);
    issue(enc(6'h08, 1, 1, 7, 1), 0, 0, 0, 0, 0);
    issue(enc(0, 1, 2, 7, 6'h22), 0, 0, 0, 0, 0);

    issue(enc(0, 1, 1, 4, 1), 1, enc(0, 4, 4, 5, 1), 0, 0, 0);
    issue(enc(0, 4, 4, 5, 1), 0, 0, 0, 0, 0);

    issue(enc(0, 1, 1, 8, 1), 0, 0, 0, 0, 0);
    issue(enc(0, 2, 2, 9, 1), 0, 0, 0, 0, 0);
    @(negedge clk); carry_clr = 1'b1;
    @(negedge clk); carry_clr = 1'b0;
`ifdef ALU_ISSUE_STICKY_CARRY_EN
    mflag = 1'b0;
`endif
    chk("clr_flag", 32'(carry_flag), 32'(mflag));
    issue(enc(0, 1, 1, 10, 1), 0, 0, 0, 0, 1);

    wait_ready();
    ib.instr_valid = 1'b1; ib.instr = enc(0, 1, 1, 6, 1);
    @(posedge clk); #1;
    ib.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; #1;
    for (int i = 0; i < 32; i++) m[i] = '0;
    mflag = 1'b0;
    chk("ar_src1", Src_1, 32'd0);
    chk("ar_src2", Src_2, 32'd0);
    chk("ar_funct", 32'(Funct), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_err", 32'(err), 32'd0);
    chk("ar_wb", wb_data, 32'd0);
    chk("ar_flag", 32'(carry_flag), 32'd0);
    chk("ar_ready", 32'(ib.instr_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; dbg_addr = 5'd6; #1;
    chk("ar_r6", dbg_data, 32'd0);
    dbg_addr = 5'd1; #1;
    chk("ar_r1", dbg_data, 32'd0);
    issue(enc(0, 0, 0, 6, 0), 0, 0, 1, 32'd5, 0);

    for (int k = 0; k < 40; k++) begin
      r  = $urandom_range(0, 9);
      fn = (r < 4) ? 6'h00 : (r < 9) ? 6'h01 : 6'h22;
      op = ($urandom_range(0, 9) == 0) ? 6'h08 : 6'h00;
      ov = (fn == 6'h00) && ($urandom_range(0, 1) == 1);
      issue(enc(op, 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), fn),
            0, 0, ov, $urandom, $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
